// File: rtl/axis2tap_pkg.sv
// Shared types and helpers for the AXIS TX framer and the RX-side checker.
package axis2tap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        IFG  = 2'd3
    } tx_framer_state_t;

    localparam logic [63:0] PREAMBLE_WORD = 64'h5555555555555555;
    localparam logic [63:0] SFD_WORD      = 64'hD555555555555555;

    // Wide enough for ceil(255/8) = 32 idle cycles.
    localparam int GAP_W = 6;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/axis_tx_ifg_calc.sv
// Maps the tkeep of a final beat to the number of idle cycles needed so that
// at least N_IFG idle bytes separate the last data byte from the next preamble.
module axis_tx_ifg_calc
    import axis2tap_pkg::*;
#(
    parameter int N_IFG = 12
) (
    input  logic [7:0]       tkeep_i,
    output logic [GAP_W-1:0] gap_o
);

    localparam logic [8:0] IFG_BYTES = 9'(N_IFG);

    logic [3:0] idle_bytes;
    logic [8:0] residual;

    // Empty lanes of the last beat already count toward the gap.
    always_comb begin
        idle_bytes = 4'd8 - popcount8(tkeep_i);
        if (IFG_BYTES > {5'd0, idle_bytes}) begin
            residual = IFG_BYTES - {5'd0, idle_bytes};
        end else begin
            residual = 9'd0;
        end
        gap_o = GAP_W'((residual + 9'd7) >> 3);
    end

endmodule

// File: rtl/axis_tx_framer.sv
// 64-bit AXIS TX framer: prepends preamble/SFD beats and enforces the IFG.
// Packet/byte/error counters exist only when TX_STATS_EN is defined.
module axis_tx_framer
    import axis2tap_pkg::*;
#(
    parameter int N_PREAMBLE = 8,
    parameter int N_IFG      = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [31:0] tx_pkt_count,
    output logic [47:0] tx_byte_count,
    output logic [15:0] tx_err_count
);

    localparam int PRE_BEATS = N_PREAMBLE / 8;
    localparam int BEAT_W    = (PRE_BEATS > 1) ? $clog2(PRE_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PRE_BEATS - 1);

    tx_framer_state_t  state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [GAP_W-1:0]  ifg_q, ifg_d;
    logic [GAP_W-1:0]  gap;
    logic              s_xfer;
    logic              last_xfer;
    logic              pre_last;

    axis_tx_ifg_calc #(
        .N_IFG (N_IFG)
    ) u_ifg_calc (
        .tkeep_i (s_axis_tkeep),
        .gap_o   (gap)
    );

    assign s_xfer    = (state_q == DATA) && s_axis_tvalid && m_axis_tready;
    assign last_xfer = s_xfer && s_axis_tlast;
    assign pre_last  = (beat_q == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            ifg_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            ifg_q   <= ifg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        ifg_d   = ifg_q;
        case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    state_d = PRE;
                    beat_d  = '0;
                end
            end
            PRE: begin
                if (m_axis_tready) begin
                    if (pre_last) begin
                        state_d = DATA;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (last_xfer) begin
                    if (gap == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = IFG;
                        ifg_d   = gap;
                    end
                end
            end
            IFG: begin
                if (ifg_q <= GAP_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    ifg_d = ifg_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // DATA is a pure combinational pass-through so upstream stalls add no bubbles.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        case (state_q)
            PRE: begin
                m_axis_tvalid = 1'b1;
                m_axis_tkeep  = 8'hFF;
                m_axis_tdata  = pre_last ? SFD_WORD : PREAMBLE_WORD;
            end
            DATA: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tkeep  = s_axis_tkeep;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
            end
            default: ;
        endcase
    end

`ifdef TX_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [47:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        byte_cnt_d = byte_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (s_xfer) begin
            byte_cnt_d = byte_cnt_q + {44'd0, popcount8(s_axis_tkeep)};
        end
        if (last_xfer) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            err_cnt_d = err_cnt_q + {15'd0, s_axis_tuser};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            byte_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign tx_pkt_count  = pkt_cnt_q;
    assign tx_byte_count = byte_cnt_q;
    assign tx_err_count  = err_cnt_q;
`else
    assign tx_pkt_count  = '0;
    assign tx_byte_count = '0;
    assign tx_err_count  = '0;
`endif

endmodule

// File: tb/tb_axis_tx_framer.sv
// Directed bench for axis_tx_framer: default instance plus an N_PREAMBLE=16, N_IFG=0 instance.
module tb_axis_tx_framer;

`ifdef TX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [63:0] PRE_W = 64'h5555555555555555;
    localparam logic [63:0] SFD_W = 64'hD555555555555555;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid, s_tlast, s_tuser, m_tready;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;

    logic        s_tready, m_tvalid, m_tlast, m_tuser;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic [31:0] pkt_cnt;
    logic [47:0] byte_cnt;
    logic [15:0] err_cnt;

    logic        s2_tready, m2_tvalid, m2_tlast, m2_tuser;
    logic [63:0] m2_tdata;
    logic [7:0]  m2_tkeep;
    logic [31:0] pkt_cnt2;
    logic [47:0] byte_cnt2;
    logic [15:0] err_cnt2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    axis_tx_framer dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .tx_pkt_count(pkt_cnt), .tx_byte_count(byte_cnt), .tx_err_count(err_cnt)
    );

    axis_tx_framer #(.N_PREAMBLE(16), .N_IFG(0)) dut2 (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s2_tready), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m2_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m2_tdata),
        .m_axis_tkeep(m2_tkeep), .m_axis_tlast(m2_tlast), .m_axis_tuser(m2_tuser),
        .tx_pkt_count(pkt_cnt2), .tx_byte_count(byte_cnt2), .tx_err_count(err_cnt2)
    );

    // Cycle stamp and output transfer logs
    int          cyc = 0;
    logic [63:0] md [256];
    logic [7:0]  mk [256];
    logic        ml [256];
    logic        mu [256];
    int          ms [256];
    int          mon_n = 0;
    logic [63:0] md2 [256];
    logic        ml2 [256];
    int          ms2 [256];
    int          mon2_n = 0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] hd;
    logic [7:0]  hk;
    logic        hl;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_tvalid && m_tready && mon_n < 256) begin
            md[mon_n] <= m_tdata;
            mk[mon_n] <= m_tkeep;
            ml[mon_n] <= m_tlast;
            mu[mon_n] <= m_tuser;
            ms[mon_n] <= cyc;
            mon_n     <= mon_n + 1;
        end
        if (m2_tvalid && m_tready && mon2_n < 256) begin
            md2[mon2_n] <= m2_tdata;
            ml2[mon2_n] <= m2_tlast;
            ms2[mon2_n] <= cyc;
            mon2_n      <= mon2_n + 1;
        end
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!m_tvalid || m_tdata !== hd || m_tkeep !== hk || m_tlast !== hl))
                stall_viol <= stall_viol + 1;
            prev_stall <= m_tvalid && !m_tready;
            hd <= m_tdata;
            hk <= m_tkeep;
            hl <= m_tlast;
        end
    end

    function automatic logic [63:0] mkdata(input int p, input int j);
        logic [63:0] d;
        for (int b = 0; b < 8; b++) d[8*b +: 8] = 8'(p * 64 + j * 8 + b);
        return d;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        s_tdata = '0; s_tkeep = '0; m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drives one packet; returns early (no clock) once beat abort_at is presented.
    task automatic send_pkt(input int p, input int nb, input logic [7:0] lk, input logic usr,
                            input bit tog, input bit sel, input int abort_at);
        int j, guard;
        bit acc, tgl;
        j = 0; guard = 0; tgl = 1'b1;
        while (j < nb) begin
            s_tvalid = 1'b1;
            s_tdata  = mkdata(p, j);
            s_tkeep  = (j == nb - 1) ? lk : 8'hFF;
            s_tlast  = (j == nb - 1);
            s_tuser  = (j == nb - 1) ? usr : 1'b0;
            m_tready = tog ? tgl : 1'b1;
            tgl = ~tgl;
            if (j == abort_at) return;
            @(negedge clk);
            acc = s_tvalid && (sel ? s2_tready : s_tready);
            @(posedge clk);
            #1;
            if (acc) j++;
            guard++;
            if (guard > 200) begin
                n_total++;
                $display("FAIL send_pkt_timeout pkt=%0d beats_done=%0d required=%0d", p, j, nb);
                break;
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; m_tready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_tvalid = 1'b1; s_tdata = '1; s_tkeep = 8'hFF; s_tlast = 1'b1; s_tuser = 1'b1;
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if ({m_tvalid, s_tready, m_tlast, m_tuser} !== 4'b0000)
            $display("FAIL reset_ctrl got=%b required=0000", {m_tvalid, s_tready, m_tlast, m_tuser});
        else n_pass++;
        n_total++;
        if (m_tdata !== 64'd0 || m_tkeep !== 8'd0)
            $display("FAIL reset_data got=%h/%h required=0/0", m_tdata, m_tkeep);
        else n_pass++;
        n_total++;
        if (pkt_cnt !== 32'd0 || byte_cnt !== 48'd0 || err_cnt !== 16'd0)
            $display("FAIL reset_counters got=%0d/%0d/%0d required=0/0/0", pkt_cnt, byte_cnt, err_cnt);
        else n_pass++;
        n_total++;
        if (m2_tvalid !== 1'b0 || s2_tready !== 1'b0)
            $display("FAIL reset_dut2 got=%b%b required=00", m2_tvalid, s2_tready);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_single();
        int b;
        do_reset();
        b = mon_n;
        send_pkt(1, 8, 8'hFF, 1'b0, 1'b0, 1'b0, -1);
        n_total++;
        if (mon_n - b !== 9) $display("FAIL single_beats got=%0d required=9", mon_n - b);
        else n_pass++;
        n_total++;
        if (md[b] !== SFD_W || mk[b] !== 8'hFF || ml[b] !== 1'b0)
            $display("FAIL single_sfd got=%h/%h/%b required=%h/ff/0", md[b], mk[b], ml[b], SFD_W);
        else n_pass++;
        for (int j = 0; j < 8; j++) begin
            n_total++;
            if (md[b+1+j] !== mkdata(1, j))
                $display("FAIL single_data%0d got=%h required=%h", j, md[b+1+j], mkdata(1, j));
            else n_pass++;
        end
        n_total++;
        if (ml[b+8] !== 1'b1 || ml[b+7] !== 1'b0)
            $display("FAIL single_tlast got=%b%b required=01", ml[b+7], ml[b+8]);
        else n_pass++;
        n_total++;
        if (pkt_cnt !== (STATS ? 32'd1 : 32'd0) || byte_cnt !== (STATS ? 48'd64 : 48'd0) || err_cnt !== 16'd0)
            $display("FAIL single_counters got=%0d/%0d/%0d required=%0d/%0d/0",
                     pkt_cnt, byte_cnt, err_cnt, STATS ? 1 : 0, STATS ? 64 : 0);
        else n_pass++;
        send_pkt(2, 1, 8'h01, 1'b0, 1'b0, 1'b0, -1);
        n_total++;
        if (ms[b+9] - ms[b+8] !== 4)
            $display("FAIL single_ifg_ff_spacing got=%0d required=4", ms[b+9] - ms[b+8]);
        else n_pass++;
        n_total++;
        if (md[b+9] !== SFD_W || md[b+10] !== mkdata(2, 0) || mk[b+10] !== 8'h01 || ml[b+10] !== 1'b1)
            $display("FAIL single_short_pkt got=%h/%h/%h/%b", md[b+9], md[b+10], mk[b+10], ml[b+10]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int b;
        do_reset();
        b = mon_n;
        send_pkt(3, 3, 8'h0F, 1'b0, 1'b0, 1'b0, -1);
        send_pkt(4, 3, 8'h0F, 1'b0, 1'b0, 1'b0, -1);
        n_total++;
        if (mon_n - b !== 8) $display("FAIL b2b_beats got=%0d required=8", mon_n - b);
        else n_pass++;
        n_total++;
        if (ms[b+4] - ms[b+3] !== 3)
            $display("FAIL b2b_spacing got=%0d required=3", ms[b+4] - ms[b+3]);
        else n_pass++;
        n_total++;
        if (mk[b+3] !== 8'h0F || md[b+4] !== SFD_W || md[b+7] !== mkdata(4, 2))
            $display("FAIL b2b_content got=%h/%h/%h", mk[b+3], md[b+4], md[b+7]);
        else n_pass++;
        n_total++;
        if (pkt_cnt !== (STATS ? 32'd2 : 32'd0) || byte_cnt !== (STATS ? 48'd40 : 48'd0))
            $display("FAIL b2b_counters got=%0d/%0d required=%0d/%0d",
                     pkt_cnt, byte_cnt, STATS ? 2 : 0, STATS ? 40 : 0);
        else n_pass++;
    endtask

    task automatic test_stall();
        int b, sv;
        do_reset();
        b = mon_n;
        sv = stall_viol;
        send_pkt(5, 4, 8'h3F, 1'b0, 1'b1, 1'b0, -1);
        n_total++;
        if (mon_n - b !== 5) $display("FAIL stall_beats got=%0d required=5", mon_n - b);
        else n_pass++;
        n_total++;
        if (md[b] !== SFD_W) $display("FAIL stall_sfd got=%h required=%h", md[b], SFD_W);
        else n_pass++;
        for (int j = 0; j < 4; j++) begin
            n_total++;
            if (md[b+1+j] !== mkdata(5, j))
                $display("FAIL stall_data%0d got=%h required=%h", j, md[b+1+j], mkdata(5, j));
            else n_pass++;
        end
        n_total++;
        if (mk[b+4] !== 8'h3F || ml[b+4] !== 1'b1)
            $display("FAIL stall_last got=%h/%b required=3f/1", mk[b+4], ml[b+4]);
        else n_pass++;
        n_total++;
        if (stall_viol !== sv) $display("FAIL stall_stability got=%0d required=0", stall_viol - sv);
        else n_pass++;
        n_total++;
        if (byte_cnt !== (STATS ? 48'd30 : 48'd0))
            $display("FAIL stall_bytes got=%0d required=%0d", byte_cnt, STATS ? 30 : 0);
        else n_pass++;
    endtask

    task automatic test_err();
        int b;
        do_reset();
        b = mon_n;
        send_pkt(6, 2, 8'hFF, 1'b1, 1'b0, 1'b0, -1);
        n_total++;
        if (mu[b+2] !== 1'b1 || mu[b+1] !== 1'b0 || ml[b+2] !== 1'b1)
            $display("FAIL err_tuser got=%b%b/%b required=01/1", mu[b+1], mu[b+2], ml[b+2]);
        else n_pass++;
        n_total++;
        if (err_cnt !== (STATS ? 16'd1 : 16'd0) || pkt_cnt !== (STATS ? 32'd1 : 32'd0) ||
            byte_cnt !== (STATS ? 48'd16 : 48'd0))
            $display("FAIL err_counters got=%0d/%0d/%0d required=%0d/%0d/%0d", err_cnt, pkt_cnt,
                     byte_cnt, STATS ? 1 : 0, STATS ? 1 : 0, STATS ? 16 : 0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int b;
        do_reset();
        send_pkt(7, 6, 8'hFF, 1'b0, 1'b0, 1'b0, 2);
        #1;
        n_total++;
        if (m_tvalid !== 1'b1 || m_tdata !== mkdata(7, 2) || byte_cnt !== (STATS ? 48'd16 : 48'd0))
            $display("FAIL midrst_before got=%b/%h/%0d required=1/%h/%0d", m_tvalid, m_tdata,
                     byte_cnt, mkdata(7, 2), STATS ? 16 : 0);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || byte_cnt !== 48'd0 || pkt_cnt !== 32'd0)
            $display("FAIL midrst_abort got=%b%b/%0d/%0d required=00/0/0", m_tvalid, s_tready,
                     byte_cnt, pkt_cnt);
        else n_pass++;
        s_tvalid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        b = mon_n;
        send_pkt(8, 1, 8'hFF, 1'b0, 1'b0, 1'b0, -1);
        n_total++;
        if (mon_n - b !== 2 || md[b] !== SFD_W || md[b+1] !== mkdata(8, 0))
            $display("FAIL midrst_restart got=%0d/%h/%h required=2/%h/%h", mon_n - b, md[b],
                     md[b+1], SFD_W, mkdata(8, 0));
        else n_pass++;
        n_total++;
        if (pkt_cnt !== (STATS ? 32'd1 : 32'd0) || byte_cnt !== (STATS ? 48'd8 : 48'd0))
            $display("FAIL midrst_counters got=%0d/%0d required=%0d/%0d", pkt_cnt, byte_cnt,
                     STATS ? 1 : 0, STATS ? 8 : 0);
        else n_pass++;
    endtask

    task automatic test_param2();
        int b;
        do_reset();
        b = mon2_n;
        send_pkt(9, 2, 8'hFF, 1'b0, 1'b0, 1'b1, -1);
        send_pkt(10, 1, 8'h0F, 1'b0, 1'b0, 1'b1, -1);
        n_total++;
        if (mon2_n - b !== 7) $display("FAIL p2_beats got=%0d required=7", mon2_n - b);
        else n_pass++;
        n_total++;
        if (md2[b] !== PRE_W || md2[b+1] !== SFD_W)
            $display("FAIL p2_preamble got=%h/%h required=%h/%h", md2[b], md2[b+1], PRE_W, SFD_W);
        else n_pass++;
        n_total++;
        if (md2[b+2] !== mkdata(9, 0) || md2[b+3] !== mkdata(9, 1) || ml2[b+3] !== 1'b1)
            $display("FAIL p2_data got=%h/%h/%b", md2[b+2], md2[b+3], ml2[b+3]);
        else n_pass++;
        n_total++;
        if (ms2[b+4] - ms2[b+3] !== 2)
            $display("FAIL p2_no_ifg_spacing got=%0d required=2", ms2[b+4] - ms2[b+3]);
        else n_pass++;
        n_total++;
        if (md2[b+4] !== PRE_W || md2[b+5] !== SFD_W || md2[b+6] !== mkdata(10, 0))
            $display("FAIL p2_second got=%h/%h/%h", md2[b+4], md2[b+5], md2[b+6]);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_err();
        test_reset_mid();
        test_param2();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
